// File: rtl/z80fi_insn_recorder_pkg.sv
// Shared types for the z80fi instruction recorder: M-cycle codes, byte limit, FSM states.
package z80fi_pkg;

    typedef enum logic [2:0] {
        CYCLE_NONE     = 3'd0,
        CYCLE_M1       = 3'd1,
        CYCLE_RD_MEM   = 3'd2,
        CYCLE_WR_MEM   = 3'd3,
        CYCLE_RDWR_MEM = 3'd4,
        CYCLE_RD_IO    = 3'd5,
        CYCLE_WR_IO    = 3'd6,
        CYCLE_INTACK   = 3'd7
    } mcycle_t;

    localparam int INSN_MAX_BYTES = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } rec_state_t;

endpackage

// File: rtl/z80fi_insn_recorder_if.sv
// Trace-event inputs and record outputs of the recorder; the optional z80fi_order
// field exists only when Z80FI_ORDER_EN is defined.
interface z80fi_insn_recorder_if #(
    parameter int NUM_MCYCLES = 6
);
    logic                       fetch_valid;
    logic [7:0]                 fetch_byte;
    logic                       mcycle_done;
    logic [2:0]                 mcycle_type;
    logic [3:0]                 mcycle_tcycles;
    logic                       mem_rd_valid;
    logic [15:0]                mem_raddr;
    logic [7:0]                 mem_rdata;
    logic                       mem_wr_valid;
    logic [15:0]                mem_waddr;
    logic [7:0]                 mem_wdata;
    logic                       insn_retire;

    logic                       z80fi_valid;
    logic [31:0]                z80fi_insn;
    logic [2:0]                 z80fi_insn_len;
    logic [3*NUM_MCYCLES-1:0]   z80fi_mcycle_type;
    logic [4*NUM_MCYCLES-1:0]   z80fi_tcycles;
    logic [15:0]                z80fi_bus_raddr;
    logic [7:0]                 z80fi_bus_rdata;
    logic [15:0]                z80fi_bus_waddr;
    logic [7:0]                 z80fi_bus_wdata;
    logic                       z80fi_rd_seen;
    logic                       z80fi_wr_seen;
    logic                       z80fi_overflow;
`ifdef Z80FI_ORDER_EN
    logic [63:0]                z80fi_order;
`endif

    // The core-side trace source drives events and observes records.
    modport master (
        output fetch_valid, fetch_byte, mcycle_done, mcycle_type, mcycle_tcycles,
               mem_rd_valid, mem_raddr, mem_rdata, mem_wr_valid, mem_waddr, mem_wdata,
               insn_retire,
        input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_mcycle_type, z80fi_tcycles,
               z80fi_bus_raddr, z80fi_bus_rdata, z80fi_bus_waddr, z80fi_bus_wdata,
               z80fi_rd_seen, z80fi_wr_seen, z80fi_overflow
`ifdef Z80FI_ORDER_EN
        , input z80fi_order
`endif
    );

    modport slave (
        input  fetch_valid, fetch_byte, mcycle_done, mcycle_type, mcycle_tcycles,
               mem_rd_valid, mem_raddr, mem_rdata, mem_wr_valid, mem_waddr, mem_wdata,
               insn_retire,
        output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_mcycle_type, z80fi_tcycles,
               z80fi_bus_raddr, z80fi_bus_rdata, z80fi_bus_waddr, z80fi_bus_wdata,
               z80fi_rd_seen, z80fi_wr_seen, z80fi_overflow
`ifdef Z80FI_ORDER_EN
        , output z80fi_order
`endif
    );

endinterface

// File: rtl/z80fi_insn_recorder_mcycle_log.sv
// M-cycle slot log: in-order slot fill, overflow flag, and a merged view that already
// includes the M-cycle ending this cycle so a retire in the same cycle sees it.
module z80fi_mcycle_log
    import z80fi_pkg::*;
#(
    parameter int NUM_MCYCLES = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  mcycle_t                  push_type,
    input  logic [3:0]               push_tc,
    input  logic                     clear,
    output logic [3*NUM_MCYCLES-1:0] types_merged,
    output logic [4*NUM_MCYCLES-1:0] tc_merged,
    output logic                     ovf_merged
);
    localparam int PW = $clog2(NUM_MCYCLES + 1);
    localparam logic [PW-1:0] FULL = PW'(NUM_MCYCLES);

    logic [PW-1:0] wptr_reg;
    logic          ovf_reg;
    logic          full;

    assign full       = (wptr_reg == FULL);
    assign ovf_merged = ovf_reg | (push & full);

    generate
        for (genvar gi = 0; gi < NUM_MCYCLES; gi++) begin : g_slot
            mcycle_t    type_reg;
            logic [3:0] tc_reg;
            logic       hit;

            assign hit = push && !full && (wptr_reg == PW'(gi));
            assign types_merged[3*gi +: 3] = hit ? push_type : type_reg;
            assign tc_merged[4*gi +: 4]    = hit ? push_tc   : tc_reg;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    type_reg <= CYCLE_NONE;
                    tc_reg   <= 4'd0;
                end else if (hit) begin
                    type_reg <= push_type;
                    tc_reg   <= push_tc;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wptr_reg <= '0;
            ovf_reg  <= 1'b0;
        end else if (push) begin
            if (full) begin
                ovf_reg <= 1'b1;
            end else begin
                wptr_reg <= wptr_reg + PW'(1);
            end
        end
    end

endmodule

// File: rtl/z80fi_insn_recorder.sv
// Collects one instruction's trace events and emits a single-cycle z80fi record on retire.
// Defining Z80FI_ORDER_EN adds the 64-bit retired-record sequence number z80fi_order.
module z80fi_insn_recorder
    import z80fi_pkg::*;
#(
    parameter int NUM_MCYCLES = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    z80fi_insn_recorder_if.slave  bus
);
    localparam logic [2:0] LEN_MAX = 3'(INSN_MAX_BYTES);

    rec_state_t  state_reg;
    logic [2:0]  len_reg;
    logic [31:0] bytes_reg;
    logic        byte_ovf_reg;
    logic        rd_seen_reg, wr_seen_reg;
    logic [15:0] raddr_reg, waddr_reg;
    logic [7:0]  rdata_reg, wdata_reg;

    logic [2:0]  len_next;
    logic [31:0] bytes_next;
    logic        byte_take, byte_ovf_next, rd_take, wr_take, any_event;
    logic [15:0] raddr_next, waddr_next;
    logic [7:0]  rdata_next, wdata_next;

    logic [3*NUM_MCYCLES-1:0] types_merged;
    logic [4*NUM_MCYCLES-1:0] tc_merged;
    logic                     mc_ovf_merged;

    // "_next" values are the accumulators with this cycle's events already merged in.
    assign byte_take     = bus.fetch_valid && (len_reg != LEN_MAX);
    assign len_next      = len_reg + 3'(byte_take);
    assign byte_ovf_next = byte_ovf_reg | (bus.fetch_valid & (len_reg == LEN_MAX));

    generate
        for (genvar gi = 0; gi < INSN_MAX_BYTES; gi++) begin : g_byte
            assign bytes_next[8*gi +: 8] = (byte_take && len_reg == 3'(gi))
                                           ? bus.fetch_byte : bytes_reg[8*gi +: 8];
        end
    endgenerate

    assign rd_take    = bus.mem_rd_valid && !rd_seen_reg;
    assign wr_take    = bus.mem_wr_valid && !wr_seen_reg;
    assign raddr_next = rd_take ? bus.mem_raddr : raddr_reg;
    assign rdata_next = rd_take ? bus.mem_rdata : rdata_reg;
    assign waddr_next = wr_take ? bus.mem_waddr : waddr_reg;
    assign wdata_next = wr_take ? bus.mem_wdata : wdata_reg;
    assign any_event  = bus.fetch_valid | bus.mcycle_done | bus.mem_rd_valid | bus.mem_wr_valid;

    z80fi_mcycle_log #(.NUM_MCYCLES(NUM_MCYCLES)) u_mcycle_log (
        .clk          (clk),
        .reset        (reset),
        .push         (bus.mcycle_done),
        .push_type    (mcycle_t'(bus.mcycle_type)),
        .push_tc      (bus.mcycle_tcycles),
        .clear        (bus.insn_retire),
        .types_merged (types_merged),
        .tc_merged    (tc_merged),
        .ovf_merged   (mc_ovf_merged)
    );

`ifdef Z80FI_ORDER_EN
    logic [63:0] order_cnt_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg             <= IDLE;
            len_reg               <= 3'd0;
            bytes_reg             <= 32'd0;
            byte_ovf_reg          <= 1'b0;
            rd_seen_reg           <= 1'b0;
            wr_seen_reg           <= 1'b0;
            raddr_reg             <= 16'd0;
            rdata_reg             <= 8'd0;
            waddr_reg             <= 16'd0;
            wdata_reg             <= 8'd0;
            bus.z80fi_valid       <= 1'b0;
            bus.z80fi_insn        <= 32'd0;
            bus.z80fi_insn_len    <= 3'd0;
            bus.z80fi_mcycle_type <= {NUM_MCYCLES{3'(CYCLE_NONE)}};
            bus.z80fi_tcycles     <= '0;
            bus.z80fi_bus_raddr   <= 16'd0;
            bus.z80fi_bus_rdata   <= 8'd0;
            bus.z80fi_bus_waddr   <= 16'd0;
            bus.z80fi_bus_wdata   <= 8'd0;
            bus.z80fi_rd_seen     <= 1'b0;
            bus.z80fi_wr_seen     <= 1'b0;
            bus.z80fi_overflow    <= 1'b0;
`ifdef Z80FI_ORDER_EN
            bus.z80fi_order       <= 64'd0;
            order_cnt_reg         <= 64'd0;
`endif
        end else begin
            bus.z80fi_valid <= 1'b0;
            if (bus.insn_retire) begin
                // A retire with no fetched byte is not an instruction; drop it silently.
                if (len_next != 3'd0) begin
                    bus.z80fi_valid       <= 1'b1;
                    bus.z80fi_insn        <= bytes_next;
                    bus.z80fi_insn_len    <= len_next;
                    bus.z80fi_mcycle_type <= types_merged;
                    bus.z80fi_tcycles     <= tc_merged;
                    bus.z80fi_bus_raddr   <= raddr_next;
                    bus.z80fi_bus_rdata   <= rdata_next;
                    bus.z80fi_bus_waddr   <= waddr_next;
                    bus.z80fi_bus_wdata   <= wdata_next;
                    bus.z80fi_rd_seen     <= rd_seen_reg | bus.mem_rd_valid;
                    bus.z80fi_wr_seen     <= wr_seen_reg | bus.mem_wr_valid;
                    bus.z80fi_overflow    <= byte_ovf_next | mc_ovf_merged;
`ifdef Z80FI_ORDER_EN
                    bus.z80fi_order       <= order_cnt_reg;
                    order_cnt_reg         <= order_cnt_reg + 64'd1;
`endif
                end
                state_reg    <= IDLE;
                len_reg      <= 3'd0;
                bytes_reg    <= 32'd0;
                byte_ovf_reg <= 1'b0;
                rd_seen_reg  <= 1'b0;
                wr_seen_reg  <= 1'b0;
                raddr_reg    <= 16'd0;
                rdata_reg    <= 8'd0;
                waddr_reg    <= 16'd0;
                wdata_reg    <= 8'd0;
            end else begin
                if (state_reg == IDLE && any_event) begin
                    state_reg <= COLLECT;
                end
                len_reg      <= len_next;
                bytes_reg    <= bytes_next;
                byte_ovf_reg <= byte_ovf_next;
                rd_seen_reg  <= rd_seen_reg | bus.mem_rd_valid;
                wr_seen_reg  <= wr_seen_reg | bus.mem_wr_valid;
                raddr_reg    <= raddr_next;
                rdata_reg    <= rdata_next;
                waddr_reg    <= waddr_next;
                wdata_reg    <= wdata_next;
            end
        end
    end

endmodule

// File: tb/tb_z80fi_insn_recorder.sv
// Randomised + directed bench for z80fi_insn_recorder against a queue-based record model.
// Order checks are compiled in when Z80FI_ORDER_EN is defined.
module tb_z80fi_insn_recorder;
    import z80fi_pkg::*;

    localparam int N = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    z80fi_insn_recorder_if #(.NUM_MCYCLES(N)) bus ();

    z80fi_insn_recorder #(.NUM_MCYCLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_en    = 1'b0;

    // Model: raw event queues for the instruction in flight plus the expected held record.
    logic [7:0]  byte_q[$];
    logic [6:0]  mc_q[$];
    logic [23:0] rd_q[$];
    logic [23:0] wr_q[$];

    logic              exp_valid;
    logic [31:0]       exp_insn;
    logic [2:0]        exp_len;
    logic [3*N-1:0]    exp_types;
    logic [4*N-1:0]    exp_tc;
    logic [15:0]       exp_raddr, exp_waddr;
    logic [7:0]        exp_rdata, exp_wdata;
    logic              exp_rd_seen, exp_wr_seen, exp_ovf;
    logic [63:0]       exp_order;
    logic [63:0]       model_order;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_inputs();
        bus.fetch_valid    = 1'b0;
        bus.fetch_byte     = 8'h00;
        bus.mcycle_done    = 1'b0;
        bus.mcycle_type    = 3'd0;
        bus.mcycle_tcycles = 4'd0;
        bus.mem_rd_valid   = 1'b0;
        bus.mem_raddr      = 16'h0;
        bus.mem_rdata      = 8'h0;
        bus.mem_wr_valid   = 1'b0;
        bus.mem_waddr      = 16'h0;
        bus.mem_wdata      = 8'h0;
        bus.insn_retire    = 1'b0;
    endtask

    task automatic model_clear();
        byte_q.delete();
        mc_q.delete();
        rd_q.delete();
        wr_q.delete();
    endtask

    task automatic model_step();
        exp_valid = 1'b0;
        if (reset) begin
            model_clear();
            exp_insn = '0; exp_len = '0; exp_types = '0; exp_tc = '0;
            exp_raddr = '0; exp_rdata = '0; exp_waddr = '0; exp_wdata = '0;
            exp_rd_seen = 1'b0; exp_wr_seen = 1'b0; exp_ovf = 1'b0;
            exp_order = '0; model_order = '0;
            return;
        end
        if (bus.fetch_valid)  byte_q.push_back(bus.fetch_byte);
        if (bus.mcycle_done)  mc_q.push_back({bus.mcycle_type, bus.mcycle_tcycles});
        if (bus.mem_rd_valid) rd_q.push_back({bus.mem_raddr, bus.mem_rdata});
        if (bus.mem_wr_valid) wr_q.push_back({bus.mem_waddr, bus.mem_wdata});
        if (bus.insn_retire) begin
            if (byte_q.size() != 0) begin
                exp_valid = 1'b1;
                exp_insn  = '0;
                for (int i = 0; i < byte_q.size() && i < 4; i++) exp_insn[8*i +: 8] = byte_q[i];
                exp_len   = (byte_q.size() > 4) ? 3'd4 : 3'(byte_q.size());
                exp_types = '0;
                exp_tc    = '0;
                for (int k = 0; k < N && k < mc_q.size(); k++)
                    {exp_types[3*k +: 3], exp_tc[4*k +: 4]} = mc_q[k];
                exp_ovf     = (byte_q.size() > 4) || (mc_q.size() > N);
                exp_rd_seen = (rd_q.size() != 0);
                exp_wr_seen = (wr_q.size() != 0);
                {exp_raddr, exp_rdata} = exp_rd_seen ? rd_q[0] : 24'h0;
                {exp_waddr, exp_wdata} = exp_wr_seen ? wr_q[0] : 24'h0;
                exp_order   = model_order;
                model_order = model_order + 64'd1;
            end
            model_clear();
        end
    endtask

    // One clock: inputs set beforehand are sampled at this edge, then cleared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        clear_inputs();
    endtask

    task automatic set_mc(input logic [2:0] t, input logic [3:0] tc);
        bus.mcycle_done    = 1'b1;
        bus.mcycle_type    = t;
        bus.mcycle_tcycles = tc;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid",    bus.z80fi_valid,       exp_valid);
            chk("insn",     bus.z80fi_insn,        exp_insn);
            chk("len",      bus.z80fi_insn_len,    exp_len);
            chk("types",    bus.z80fi_mcycle_type, exp_types);
            chk("tcycles",  bus.z80fi_tcycles,     exp_tc);
            chk("raddr",    bus.z80fi_bus_raddr,   exp_raddr);
            chk("rdata",    bus.z80fi_bus_rdata,   exp_rdata);
            chk("waddr",    bus.z80fi_bus_waddr,   exp_waddr);
            chk("wdata",    bus.z80fi_bus_wdata,   exp_wdata);
            chk("rd_seen",  bus.z80fi_rd_seen,     exp_rd_seen);
            chk("wr_seen",  bus.z80fi_wr_seen,     exp_wr_seen);
            chk("overflow", bus.z80fi_overflow,    exp_ovf);
`ifdef Z80FI_ORDER_EN
            chk("order",    bus.z80fi_order,       exp_order);
`endif
        end
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        cmp_en = 1'b1;
        step();
        chk("rst_valid", bus.z80fi_valid, 1'b0);
        chk("rst_types", bus.z80fi_mcycle_type, {N{3'(CYCLE_NONE)}});
        reset = 1'b0;

        // BIT 2,(HL)
        bus.fetch_valid = 1'b1; bus.fetch_byte = 8'hCB; set_mc(CYCLE_M1, 4'd4); step();
        bus.fetch_valid = 1'b1; bus.fetch_byte = 8'h56; set_mc(CYCLE_M1, 4'd4); step();
        set_mc(CYCLE_RDWR_MEM, 4'd4);
        bus.mem_rd_valid = 1'b1; bus.mem_raddr = 16'h1234; bus.mem_rdata = 8'h04;
        bus.insn_retire = 1'b1;
        step();
        chk("bit_valid",   bus.z80fi_valid, 1'b1);
        chk("bit_insn",    bus.z80fi_insn, 32'h000056CB);
        chk("bit_model",   exp_insn, 32'h000056CB);
        chk("bit_len",     bus.z80fi_insn_len, 3'd2);
        chk("bit_types",   bus.z80fi_mcycle_type, 18'h00109);
        chk("bit_tc",      bus.z80fi_tcycles, 24'h000444);
        chk("bit_raddr",   bus.z80fi_bus_raddr, 16'h1234);
        chk("bit_rdata",   bus.z80fi_bus_rdata, 8'h04);
        chk("bit_rd_seen", bus.z80fi_rd_seen, 1'b1);
        chk("bit_wr_seen", bus.z80fi_wr_seen, 1'b0);
        step();
        chk("bit_pulse",   bus.z80fi_valid, 1'b0);

        // NOP, NOP retiring on consecutive cycles
        for (int n = 0; n < 2; n++) begin
            bus.fetch_valid = 1'b1; bus.fetch_byte = 8'h00; set_mc(CYCLE_M1, 4'd4);
            bus.insn_retire = 1'b1;
            step();
            chk("nop_valid", bus.z80fi_valid, 1'b1);
            chk("nop_insn",  bus.z80fi_insn, 32'h0);
            chk("nop_len",   bus.z80fi_insn_len, 3'd1);
            chk("nop_types", bus.z80fi_mcycle_type, 18'h00001);
            chk("nop_tc",    bus.z80fi_tcycles, 24'h000004);
        end

        // Five bytes and seven M-cycles
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin bus.fetch_valid = 1'b1; bus.fetch_byte = 8'(8'h11 * (i + 1)); end
            set_mc(CYCLE_M1, 4'd4);
            bus.insn_retire = (i == 6);
            step();
        end
        chk("ovf_insn",  bus.z80fi_insn, 32'h44332211);
        chk("ovf_len",   bus.z80fi_insn_len, 3'd4);
        chk("ovf_flag",  bus.z80fi_overflow, 1'b1);
        chk("ovf_types", bus.z80fi_mcycle_type, 18'h09249);
        chk("ovf_tc",    bus.z80fi_tcycles, 24'h444444);

        // One byte but seven M-cycles: M-cycle overflow alone
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin bus.fetch_valid = 1'b1; bus.fetch_byte = 8'h76; end
            set_mc(CYCLE_RD_MEM, 4'd3);
            bus.insn_retire = (i == 6);
            step();
        end
        chk("mcovf_len",  bus.z80fi_insn_len, 3'd1);
        chk("mcovf_flag", bus.z80fi_overflow, 1'b1);

        // Two reads: only the first is kept
        bus.fetch_valid = 1'b1; bus.fetch_byte = 8'h7E;
        bus.mem_rd_valid = 1'b1; bus.mem_raddr = 16'h0010; bus.mem_rdata = 8'hAA;
        step();
        bus.mem_rd_valid = 1'b1; bus.mem_raddr = 16'h0020; bus.mem_rdata = 8'hBB;
        bus.insn_retire = 1'b1;
        step();
        chk("rd2_raddr", bus.z80fi_bus_raddr, 16'h0010);
        chk("rd2_rdata", bus.z80fi_bus_rdata, 8'hAA);

        // Retire without any fetched byte is dropped
        set_mc(CYCLE_M1, 4'd4); step();
        bus.insn_retire = 1'b1; step();
        chk("len0_valid", bus.z80fi_valid, 1'b0);

        // Reset mid-collect discards the partial record
        bus.fetch_valid = 1'b1; bus.fetch_byte = 8'h01; step();
        bus.fetch_valid = 1'b1; bus.fetch_byte = 8'h02; step();
        reset = 1'b1; step();
        reset = 1'b0;
        bus.fetch_valid = 1'b1; bus.fetch_byte = 8'h3C; bus.insn_retire = 1'b1; step();
        chk("rstmid_valid", bus.z80fi_valid, 1'b1);
        chk("rstmid_len",   bus.z80fi_insn_len, 3'd1);
        chk("rstmid_insn",  bus.z80fi_insn, 32'h0000003C);

        // Reset together with retire: no emit
        bus.fetch_valid = 1'b1; bus.fetch_byte = 8'h00; bus.insn_retire = 1'b1;
        reset = 1'b1; step();
        reset = 1'b0;
        chk("rstret_valid", bus.z80fi_valid, 1'b0);

`ifdef Z80FI_ORDER_EN
        for (int n = 0; n < 3; n++) begin
            bus.fetch_valid = 1'b1; bus.fetch_byte = 8'h00; bus.insn_retire = 1'b1;
            step();
            chk("ord_seq", bus.z80fi_order, 64'(n));
            if (n == 1) begin
                set_mc(CYCLE_M1, 4'd4); bus.insn_retire = 1'b1; step();
                chk("ord_len0_valid", bus.z80fi_valid, 1'b0);
            end
        end
`endif

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            bus.fetch_valid    = ($urandom_range(0, 99) < 40);
            bus.fetch_byte     = 8'($urandom);
            bus.mcycle_done    = ($urandom_range(0, 99) < 35);
            bus.mcycle_type    = 3'($urandom);
            bus.mcycle_tcycles = 4'($urandom);
            bus.mem_rd_valid   = ($urandom_range(0, 99) < 20);
            bus.mem_raddr      = 16'($urandom);
            bus.mem_rdata      = 8'($urandom);
            bus.mem_wr_valid   = ($urandom_range(0, 99) < 15);
            bus.mem_waddr      = 16'($urandom);
            bus.mem_wdata      = 8'($urandom);
            bus.insn_retire    = ($urandom_range(0, 99) < 18);
            reset              = ($urandom_range(0, 99) < 2);
            step();
        end
        reset = 1'b0;
        step();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
